// File: rtl/ps2_kbd_tx.sv
// Purpose: PS/2 device-side transmitter; bytes queue in a FIFO and go out as 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Latency: a push into an empty idle block drives the start bit two edges later; a frame takes 22*CLK_DIV cycles plus GAP_CYCLES idle.
// Backpressure: in_ready drops when the FIFO is full; host inhibit holds off a frame start or aborts a frame before its stop bit.
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [7:0]                        in_data,
    output logic                              in_ready,
    input  logic                              inhibit,
    output logic                              ps2_clk,
    output logic                              ps2_dat,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              tx_done,
    output logic                              tx_abort
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q;
    logic          push, pop;
    logic [7:0]    head_dat;

    // Frame sequencer state
    state_t        state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [10:0]   shift_q, shift_d;
    logic          done_evt, abort_evt;

    // Registered line drivers and event pulses
    logic          clk_d, dat_d, busy_d;
    logic          ps2_clk_q, ps2_dat_q, busy_q;
    logic          done_s_q, abort_s_q;
    logic          tx_done_q, tx_abort_q;

    assign push     = in_valid & in_ready_q;
    assign pop      = done_evt;
    assign head_dat = mem_q[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, count and registered ready flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            in_ready_q <= (count_d < CW'(FIFO_DEPTH));
        end
    end

    // FIFO data array; contents are meaningless once the pointers are cleared
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // Sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
        end
    end

    // Next-state: phase timing, bit stepping, abort before the stop bit, pop on completion
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        div_d     = div_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        done_evt  = 1'b0;
        abort_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && !inhibit) begin
                    // head byte is only copied; it leaves the FIFO when the frame completes
                    state_d = ST_HIGH;
                    bit_d   = 4'd0;
                    div_d   = DW'(CLK_DIV);
                    shift_d = {1'b1, ~^head_dat, head_dat, 1'b0};
                end
            end
            ST_HIGH: begin
                if (inhibit && (bit_q != 4'd10)) begin
                    state_d   = ST_GAP;
                    gap_d     = GW'(GAP_CYCLES);
                    abort_evt = 1'b1;
                end else if (div_q == DW'(1)) begin
                    state_d = ST_LOW;
                    div_d   = DW'(CLK_DIV);
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            ST_LOW: begin
                if (inhibit && (bit_q != 4'd10)) begin
                    state_d   = ST_GAP;
                    gap_d     = GW'(GAP_CYCLES);
                    abort_evt = 1'b1;
                end else if (div_q == DW'(1)) begin
                    if (bit_q == 4'd10) begin
                        state_d  = ST_GAP;
                        gap_d    = GW'(GAP_CYCLES);
                        done_evt = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                        bit_d   = bit_q + 4'd1;
                        div_d   = DW'(CLK_DIV);
                        shift_d = {1'b1, shift_q[10:1]};
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(1)) state_d = ST_IDLE;
                else                 gap_d   = gap_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line levels per state; the current bit sits in shift_q[0]
    always_comb begin
        clk_d  = 1'b1;
        dat_d  = 1'b1;
        busy_d = 1'b1;
        case (state_q)
            ST_IDLE: busy_d = 1'b0;
            ST_HIGH: dat_d  = shift_q[0];
            ST_LOW: begin
                clk_d = 1'b0;
                dat_d = shift_q[0];
            end
            default: begin
                clk_d = 1'b1;
                dat_d = 1'b1;
            end
        endcase
    end

    // Output registers; pulses take one extra stage so they line up with the line change they report
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps2_clk_q  <= 1'b1;
            ps2_dat_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_s_q   <= 1'b0;
            abort_s_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_abort_q <= 1'b0;
        end else begin
            ps2_clk_q  <= clk_d;
            ps2_dat_q  <= dat_d;
            busy_q     <= busy_d;
            done_s_q   <= done_evt;
            abort_s_q  <= abort_evt;
            tx_done_q  <= done_s_q;
            tx_abort_q <= abort_s_q;
        end
    end

    assign in_ready   = in_ready_q;
    assign fifo_count = count_q;
    assign ps2_clk    = ps2_clk_q;
    assign ps2_dat    = ps2_dat_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;
    assign tx_abort   = tx_abort_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with default parameters (CLK_DIV=2, FIFO_DEPTH=8, GAP_CYCLES=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ps2_kbd_tx;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       inhibit;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       busy;
    logic [3:0] fifo_count;
    logic       tx_done;
    logic       tx_abort;

    int checks = 0;
    int errors = 0;

    ps2_kbd_tx #(
        .CLK_DIV   (2),
        .FIFO_DEPTH(8),
        .GAP_CYCLES(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .inhibit   (inhibit),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .busy      (busy),
        .fifo_count(fifo_count),
        .tx_done   (tx_done),
        .tx_abort  (tx_abort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step until the start bit appears; returns steps taken, budget expiry is a failed check
    task automatic wait_start(input string tag, input int budget, output int n);
        n = 0;
        while (ps2_dat !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(ps2_dat), 32'(0));
    endtask

    // Capture 11 bits mid-way through each clock-low phase; optionally raise inhibit at cycle inh_at
    task automatic rx_frame(input int inh_at, output logic [10:0] fr, output logic ab);
        fr = '0;
        ab = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c == inh_at) inhibit = 1'b1;
            if ((c % 4) == 2) fr[c / 4] = ps2_dat;
            if (tx_abort === 1'b1) ab = 1'b1;
            step();
        end
    endtask

    initial begin
        logic [10:0] fr;
        logic        ab;
        int          n;
        logic [7:0]  vals [9];
        logic        pars [8];
        logic [10:0] exp_1c;

        exp_1c = 11'b10000111000;
        vals   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h5A};
        pars   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        inhibit  = 1'b0;
        repeat (3) step();

        // reset values
        check("rst_clk",   32'(ps2_clk),    32'(1));
        check("rst_dat",   32'(ps2_dat),    32'(1));
        check("rst_busy",  32'(busy),       32'(0));
        check("rst_count", 32'(fifo_count), 32'(0));
        check("rst_ready", 32'(in_ready),   32'(1));
        check("rst_done",  32'(tx_done),    32'(0));
        check("rst_abort", 32'(tx_abort),   32'(0));
        reset = 1'b0;
        repeat (2) step();

        // single 0x1C frame, cycle by cycle
        in_valid = 1'b1;
        in_data  = 8'h1C;
        step();
        in_valid = 1'b0;
        check("t1_count1", 32'(fifo_count), 32'(1));
        check("t1_busy_pre", 32'(busy), 32'(0));
        step();
        check("t1_dat_pre", 32'(ps2_dat), 32'(1));
        step();
        for (int k = 0; k < 11; k++) begin
            for (int c = 0; c < 4; c++) begin
                check("t1_lines", 32'({ps2_clk, ps2_dat}), 32'({(c < 2) ? 1'b1 : 1'b0, exp_1c[k]}));
                step();
            end
        end
        check("t1_done",  32'(tx_done),    32'(1));
        check("t1_lines_end", 32'({ps2_clk, ps2_dat}), 32'(3));
        check("t1_busy_gap", 32'(busy), 32'(1));
        check("t1_count0", 32'(fifo_count), 32'(0));
        for (int g = 0; g < 8; g++) begin
            step();
            check("t1_gap_lines", 32'({ps2_clk, ps2_dat, tx_done}), 32'(6));
        end
        check("t1_idle_busy", 32'(busy), 32'(0));

        // back-to-back 0xF0, 0x1C
        in_valid = 1'b1;
        in_data  = 8'hF0;
        step();
        in_data  = 8'h1C;
        step();
        in_valid = 1'b0;
        check("t2_count2", 32'(fifo_count), 32'(2));
        wait_start("t2_start_f0", 10, n);
        check("t2_lat", n, 1);
        rx_frame(-1, fr, ab);
        check("t2_frame_f0", 32'(fr), 32'(11'b11111100000));
        check("t2_done_f0", 32'(tx_done), 32'(1));
        check("t2_count1", 32'(fifo_count), 32'(1));
        wait_start("t2_start_1c", 50, n);
        check("t2_gap", n, 9);
        rx_frame(-1, fr, ab);
        check("t2_frame_1c", 32'(fr), 32'(exp_1c));
        check("t2_done_1c", 32'(tx_done), 32'(1));
        check("t2_count0", 32'(fifo_count), 32'(0));
        repeat (12) step();

        // fill under inhibit, ninth byte refused
        inhibit = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            check("t3_ready", 32'(in_ready), (i < 8) ? 32'(1) : 32'(0));
            step();
        end
        in_valid = 1'b0;
        check("t3_count8", 32'(fifo_count), 32'(8));
        repeat (6) step();
        check("t3_held_lines", 32'({ps2_clk, ps2_dat, busy}), 32'(6));
        inhibit = 1'b0;
        for (int j = 0; j < 8; j++) begin
            wait_start("t3_start", 60, n);
            rx_frame(-1, fr, ab);
            check("t3_frame", 32'(fr), 32'({1'b1, pars[j], vals[j], 1'b0}));
            check("t3_done", 32'(tx_done), 32'(1));
            check("t3_count", 32'(fifo_count), 32'(7 - j));
        end
        repeat (12) step();

        // abort during data bit 4 of 0xAA, then full resend
        in_valid = 1'b1;
        in_data  = 8'hAA;
        step();
        in_valid = 1'b0;
        wait_start("t4_start", 10, n);
        repeat (21) step();
        inhibit = 1'b1;
        step();
        check("t4_abort_early", 32'(tx_abort), 32'(0));
        step();
        check("t4_abort", 32'(tx_abort), 32'(1));
        check("t4_lines", 32'({ps2_clk, ps2_dat}), 32'(3));
        check("t4_count", 32'(fifo_count), 32'(1));
        check("t4_busy", 32'(busy), 32'(1));
        inhibit = 1'b0;
        step();
        check("t4_abort_pulse", 32'(tx_abort), 32'(0));
        wait_start("t4_restart", 50, n);
        rx_frame(-1, fr, ab);
        check("t4_frame", 32'(fr), 32'(11'b11101010100));
        check("t4_done", 32'(tx_done), 32'(1));
        check("t4_no_abort", 32'(ab), 32'(0));
        check("t4_count0", 32'(fifo_count), 32'(0));
        repeat (12) step();

        // inhibit during stop bit is ignored
        in_valid = 1'b1;
        in_data  = 8'h1C;
        step();
        in_valid = 1'b0;
        wait_start("t5_start", 10, n);
        rx_frame(41, fr, ab);
        check("t5_frame", 32'(fr), 32'(exp_1c));
        check("t5_done", 32'(tx_done), 32'(1));
        step();
        check("t5_no_abort", 32'({ab, tx_abort}), 32'(0));
        inhibit = 1'b0;
        repeat (12) step();

        // reset mid-frame with three bytes queued
        in_valid = 1'b1;
        in_data  = 8'h12;
        step();
        in_data  = 8'h34;
        step();
        in_data  = 8'h56;
        step();
        in_valid = 1'b0;
        wait_start("t6_start", 10, n);
        repeat (10) step();
        check("t6_count3", 32'(fifo_count), 32'(3));
        check("t6_clk_low", 32'(ps2_clk), 32'(0));
        #2 reset = 1'b1;
        #1;
        check("t6_rst_lines", 32'({ps2_clk, ps2_dat}), 32'(3));
        check("t6_rst_count", 32'(fifo_count), 32'(0));
        check("t6_rst_busy", 32'(busy), 32'(0));
        step();
        reset = 1'b0;
        ab = 1'b0;
        for (int q = 0; q < 60; q++) begin
            step();
            if ({ps2_clk, ps2_dat, busy} !== 3'b110) ab = 1'b1;
        end
        check("t6_quiet", 32'(ab), 32'(0));
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        wait_start("t6_restart", 10, n);
        rx_frame(-1, fr, ab);
        check("t6_frame", 32'(fr), 32'(11'b11010110100));
        check("t6_done", 32'(tx_done), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
- Parametrised PS/2 device-side transmitter that emulates a keyboard/mouse.
- Replaces the free-running clock divider with real framed traffic: bytes (scancodes) pushed by the testbench or a DPI feeder are buffered in a FIFO.
- Each byte is serialised as an 11-bit PS/2 frame on ps2_clk/ps2_dat, with a configurable bit rate, an inter-frame gap and host inhibit/abort handling.
- Sits in the peripheral model tree and drives the SoC PS/2 controller's input pins.

Parameters:
- CLK_DIV, 2, half-period of ps2_clk in clock cycles (≥1); 2 gives 25 MHz → 6.25 MHz.
- FIFO_DEPTH, 8, byte FIFO entries; power of two, ≥2.
- GAP_CYCLES, 8, idle cycles (clk=1, dat=1) after each completed or aborted frame (≥1).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  byte offered
- in_data  input  8  byte to send
- in_ready  output  1  FIFO not full; push occurs when in_valid&in_ready at a clock edge
- inhibit  input  1  host holding clock low; blocks or aborts transmission
- ps2_clk  output  1  PS/2 clock, idle high
- ps2_dat  output  1  PS/2 data, idle high
- busy  output  1  frame in progress (including gap)
- fifo_count  output  $clog2(FIFO_DEPTH+1)  entries held
- tx_done  output  1  one-cycle pulse when a frame's stop-bit low phase ends
- tx_abort  output  1  one-cycle pulse when a frame is aborted by inhibit

Behaviour:
- Reset (async, active-high) values:
  - ps2_clk=1, ps2_dat=1, busy=0, fifo_count=0, in_ready=1, tx_done=0, tx_abort=0.
  - FSM in IDLE; FIFO pointers cleared.
  - Reset mid-frame drops the frame and all FIFO contents; lines go high immediately.
- Frame bits, in order: b0=0 (start); b1..b8=data LSB first; b9=odd parity (~^data); b10=1 (stop).
- FSM states:
  - IDLE: lines high. If fifo_count≠0 and inhibit=0 at an edge → HIGH with bit index i=0. The head byte is copied to the shift register but not popped.
  - HIGH: ps2_clk=1, ps2_dat=b_i, for CLK_DIV cycles → LOW.
  - LOW: ps2_clk=0, ps2_dat=b_i, for CLK_DIV cycles. If i<10 → HIGH with i+1. If i=10 → pop FIFO, pulse tx_done, → GAP.
  - GAP: lines high for GAP_CYCLES cycles → IDLE.
- Latency: with FIFO empty and FSM idle, a push at edge E gives ps2_dat=0 from edge E+2. A full frame lasts 22*CLK_DIV cycles, plus GAP_CYCLES.
- Inhibit:
  - Sampled each cycle.
  - In IDLE it holds off the frame start.
  - In HIGH/LOW for i≤9, inhibit=1 aborts: next cycle ps2_clk=1, ps2_dat=1, tx_abort pulses, FSM → GAP. The byte stays at the FIFO head and is retransmitted in full later.
  - During i=10 (stop bit), inhibit is ignored and the frame completes.
  - Abort and completion never occur in the same cycle.
- FIFO:
  - in_ready is registered, equal to (fifo_count<FIFO_DEPTH).
  - A push while full is impossible by handshake; in_data is ignored when in_ready=0.
  - A push and a pop at the same edge leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- busy=1 in HIGH, LOW and GAP.
- Outputs are driven from registers (glitch-free).
- Counter widths: $clog2(CLK_DIV+1) and $clog2(GAP_CYCLES+1).

Test Plan:
- Push 0x1C, CLK_DIV=2 → ps2_dat per bit 0,0,0,1,1,1,0,0,0,0,1 (parity 0). Each bit holds 4 cycles. ps2_clk shows 11 low pulses of 2 cycles. tx_done fires 44 cycles after frame start. Lines are then idle for 8 cycles.
- Push 0xF0 then 0x1C back-to-back → 0xF0 frame with parity bit 1, then 0x1C starts exactly GAP_CYCLES+1 cycles after the 0xF0 tx_done. fifo_count goes 2→1→0.
- Push 9 bytes with in_valid held high while inhibit=1 → in_ready drops after 8 accepted, fifo_count=8, lines stay high. On release, the 8 frames go out in FIFO order.
- Assert inhibit during data bit 4 of 0xAA → tx_abort pulses, lines go high, fifo_count stays 1. After release and the gap, 0xAA is resent in full and completes with tx_done.
- Assert inhibit during the stop bit → frame completes, tx_done pulses, no tx_abort.
- Assert reset mid-frame with 3 bytes queued → ps2_clk=ps2_dat=1 immediately. fifo_count=0, busy=0. No output until new pushes arrive.
